sram_access_ctrl: RTL and testbench
===================================

Name: sram_access_ctrl

Overview:
- Sequential bus controller between the SLC-3 memory/IO path (Mem2IO side) and the external 1Mx16 asynchronous SRAM.
- Converts single-cycle read/write requests into properly timed CE/OE/WE/UB/LB strobe sequences, with programmable wait states.
- Latches read data and returns a one-cycle completion pulse.
- Owns the tristate enable for the shared Data bus.

Parameters:
- RD_WAIT, 2: cycles OE is held low per read; legal range 1..15.
- WR_WAIT, 2: cycles WE is held low per write; legal range 1..15.
- ADDR_HI, 4'h0: upper 4 bits of the 20-bit SRAM address.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge
- Reset  input  1  asynchronous, active-high reset
- req_rd  input  1  read request, sampled only in IDLE
- req_wr  input  1  write request, sampled only in IDLE
- addr  input  16  word address, latched on accept
- wdata  input  16  write data, latched on accept
- rdata  output  16  last completed read data
- ready  output  1  one-cycle completion pulse
- busy  output  1  high in every non-IDLE state
- ADDR  output  20  SRAM address, {ADDR_HI, latched addr}
- Data_write  output  16  data driven to the tristate buffer
- Data_read  input  16  data sampled from the tristate buffer
- Data_oe  output  1  tristate output enable, active-high
- CE, UB, LB, OE, WE  output  1 each  SRAM strobes, active-low

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; CE=UB=LB=OE=WE=1; Data_oe=0; ready=0; busy=0.
  - rdata=0; ADDR={ADDR_HI,16'h0}; Data_write=0; wait counter=0.
  - Reset mid-transaction aborts immediately; no completion pulse is produced afterwards.
- Moore outputs: every output is a function of registered state and latched registers only. There is no combinational path from req_* to any strobe.
- States: IDLE, RD_ACT, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - All strobes high; Data_oe=0.
  - On an edge with req_rd=1: latch addr, load counter=RD_WAIT-1, go RD_ACT.
  - Else on an edge with req_wr=1: latch addr and wdata, go WR_SETUP.
  - If both are high, read wins and the write is dropped (not queued).
- RD_ACT:
  - CE=UB=LB=OE=0; WE=1; Data_oe=0.
  - Each edge: if counter==0, capture Data_read into rdata and go DONE; else decrement the counter.
  - Duration is exactly RD_WAIT cycles.
- WR_SETUP:
  - Lasts 1 cycle: CE=UB=LB=0; OE=WE=1; Data_oe=1.
  - Load counter=WR_WAIT-1, go WR_PULSE.
- WR_PULSE:
  - Same as WR_SETUP but WE=0.
  - Counts down like RD_ACT; after WR_WAIT cycles go WR_HOLD.
- WR_HOLD:
  - Lasts 1 cycle: WE=1; CE=UB=LB=0; Data_oe=1; data held.
  - Then go DONE.
- DONE:
  - Lasts 1 cycle: strobes high; Data_oe=0; ready=1; busy=1.
  - Then go IDLE. Requests present during DONE are ignored.
- Latency, counted from the accept edge E0:
  - Read: ready is high in the cycle after edge E0+RD_WAIT. The next request can be accepted at edge E0+RD_WAIT+2.
  - Write: ready is high in the cycle after edge E0+WR_WAIT+2. The next request can be accepted at edge E0+WR_WAIT+4.
- Invariants:
  - OE and WE are never low simultaneously.
  - Data_oe is never 1 while OE=0.
  - ADDR and Data_write stay constant from the accept edge until return to IDLE.
  - rdata changes only at read completion; writes never alter it.
- Requests arriving while busy=1 are ignored, not queued. The upstream block holds its request until it sees ready.

Test Plan:
- Reset released; hold 5 idle cycles -> CE=OE=WE=UB=LB=1, Data_oe=0, ready=0, busy=0, rdata=16'h0000.
- req_rd pulse with addr=16'h3000, Data_read model returns 16'hBEEF, RD_WAIT=2 -> ADDR=20'h03000; OE/CE low for exactly 2 cycles; rdata=16'hBEEF; ready high 1 cycle after edge E0+2; busy low at edge E0+3.
- req_wr pulse with addr=16'h0012, wdata=16'h5A5A, WR_WAIT=2 -> Data_oe high for 4 cycles; WE low exactly 2 cycles (cycles 2-3); Data_write=16'h5A5A throughout; ready pulse after edge E0+4; rdata unchanged.
- req_rd and req_wr high together at addr=16'h0001 -> only the read sequence occurs; WE never low; the SRAM model records no write.
- req_rd held high continuously for 12 cycles -> back-to-back reads, one accepted every RD_WAIT+2=4 cycles; exactly 3 ready pulses.
- Reset asserted during the second WR_PULSE cycle -> WE, CE and Data_oe return to inactive within the same cycle (asynchronously); no ready pulse follows; the next read after release completes normally.

Source files
------------

// File: rtl/sram_access_ctrl_if.sv
// Request/response bus between Mem2IO and the SRAM controller, plus the SRAM pin side.
// The slave modport is the controller's view; master is the surrounding system's view.
interface sram_access_ctrl_if;
    logic        req_rd;
    logic        req_wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;
    logic        busy;
    logic [19:0] ADDR;
    logic [15:0] Data_write;
    logic [15:0] Data_read;
    logic        Data_oe;
    logic        CE;
    logic        UB;
    logic        LB;
    logic        OE;
    logic        WE;

    modport slave (
        input  req_rd, req_wr, addr, wdata, Data_read,
        output rdata, ready, busy, ADDR, Data_write, Data_oe, CE, UB, LB, OE, WE
    );

    modport master (
        output req_rd, req_wr, addr, wdata, Data_read,
        input  rdata, ready, busy, ADDR, Data_write, Data_oe, CE, UB, LB, OE, WE
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// Sequences CE/OE/WE/UB/LB strobes for a 1Mx16 async SRAM with programmable wait states.
// All outputs decode from registered state so requests never reach the strobes combinationally.
module sram_access_ctrl #(
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2,
    parameter logic [3:0]  ADDR_HI = 4'h0
) (
    input logic              Clk,
    input logic              Reset,
    sram_access_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StRdAct,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StDone
    } state_e;

    localparam logic [3:0] RdLoad = 4'(RD_WAIT - 1);
    localparam logic [3:0] WrLoad = 4'(WR_WAIT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                // Read has priority; a simultaneous write is dropped, not queued.
                if (bus.req_rd) begin
                    addr_d  = bus.addr;
                    cnt_d   = RdLoad;
                    state_d = StRdAct;
                end else if (bus.req_wr) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    state_d = StWrSetup;
                end
            end
            StRdAct: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = bus.Data_read;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWrSetup: begin
                cnt_d   = WrLoad;
                state_d = StWrPulse;
            end
            StWrPulse: begin
                if (cnt_q == 4'd0) begin
                    state_d = StWrHold;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWrHold: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.CE      = 1'b1;
        bus.UB      = 1'b1;
        bus.LB      = 1'b1;
        bus.OE      = 1'b1;
        bus.WE      = 1'b1;
        bus.Data_oe = 1'b0;
        bus.ready   = 1'b0;
        bus.busy    = (state_q != StIdle);
        unique case (state_q)
            StRdAct: begin
                bus.CE = 1'b0;
                bus.UB = 1'b0;
                bus.LB = 1'b0;
                bus.OE = 1'b0;
            end
            StWrSetup, StWrPulse, StWrHold: begin
                bus.CE      = 1'b0;
                bus.UB      = 1'b0;
                bus.LB      = 1'b0;
                bus.Data_oe = 1'b1;
                bus.WE      = (state_q == StWrPulse) ? 1'b0 : 1'b1;
            end
            StDone:  bus.ready = 1'b1;
            default: ;
        endcase
    end

    assign bus.ADDR       = {ADDR_HI, addr_q};
    assign bus.Data_write = wdata_q;
    assign bus.rdata      = rdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a simple SRAM model and per-cycle strobe monitor.
module tb_sram_access_ctrl;

    logic Clk;
    logic Reset;

    sram_access_ctrl_if bus ();

    sram_access_ctrl #(
        .RD_WAIT (2),
        .WR_WAIT (2),
        .ADDR_HI (4'h0)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [15:0] mem [0:65535];
    assign bus.Data_read = (!bus.CE && !bus.OE) ? mem[bus.ADDR[15:0]] : 16'h0000;

    int unsigned oe_low_cyc = 0;
    int unsigned we_low_cyc = 0;
    int unsigned doe_cyc    = 0;
    int unsigned ready_cyc  = 0;
    int unsigned viol       = 0;
    logic [19:0] last_wr_addr = 20'h0;
    logic [15:0] last_wr_data = 16'h0;

    always @(negedge Clk) begin
        if (!bus.OE) oe_low_cyc++;
        if (!bus.WE) we_low_cyc++;
        if (bus.Data_oe) doe_cyc++;
        if (bus.ready) ready_cyc++;
        if (!bus.WE && !bus.CE) begin
            last_wr_addr = bus.ADDR;
            last_wr_data = bus.Data_write;
        end
        if ((!bus.OE && !bus.WE) || (bus.Data_oe && !bus.OE)) viol++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // {CE,UB,LB,OE,WE}
    function automatic logic [4:0] strobes();
        return {bus.CE, bus.UB, bus.LB, bus.OE, bus.WE};
    endfunction

    int unsigned s_oe, s_we, s_doe, s_rdy;

    initial begin
        mem[16'h3000] = 16'hBEEF;
        mem[16'h0001] = 16'h1234;
        Reset       = 1'b1;
        bus.req_rd  = 1'b0;
        bus.req_wr  = 1'b0;
        bus.addr    = 16'h0000;
        bus.wdata   = 16'h0000;
        step(3);
        Reset = 1'b0;
        step(5);

        check("rst_strobes", 32'(strobes()), 32'h1F);
        check("rst_data_oe", 32'(bus.Data_oe), 32'h0);
        check("rst_ready", 32'(bus.ready), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_rdata", 32'(bus.rdata), 32'h0);
        check("rst_addr", 32'(bus.ADDR), 32'h0);
        check("rst_wdata", 32'(bus.Data_write), 32'h0);

        // Single read
        s_oe = oe_low_cyc; s_rdy = ready_cyc;
        bus.addr = 16'h3000; bus.req_rd = 1'b1;
        step(1);
        bus.req_rd = 1'b0;
        check("rd_addr", 32'(bus.ADDR), 32'h03000);
        check("rd_strobes", 32'(strobes()), 32'h01);
        check("rd_busy", 32'(bus.busy), 32'h1);
        check("rd_data_oe", 32'(bus.Data_oe), 32'h0);
        step(1);
        check("rd_ready_early", 32'(bus.ready), 32'h0);
        check("rd_oe_cyc2", 32'(bus.OE), 32'h0);
        step(1);
        check("rd_ready", 32'(bus.ready), 32'h1);
        check("rd_rdata", 32'(bus.rdata), 32'hBEEF);
        check("rd_oe_done", 32'(bus.OE), 32'h1);
        step(1);
        check("rd_busy_end", 32'(bus.busy), 32'h0);
        check("rd_oe_count", oe_low_cyc - s_oe, 32'd2);
        check("rd_ready_count", ready_cyc - s_rdy, 32'd1);

        // Single write
        s_we = we_low_cyc; s_doe = doe_cyc; s_rdy = ready_cyc;
        bus.addr = 16'h0012; bus.wdata = 16'h5A5A; bus.req_wr = 1'b1;
        step(1);
        bus.req_wr = 1'b0;
        check("wr_setup_strobes", 32'(strobes()), 32'h03);
        check("wr_setup_doe", 32'(bus.Data_oe), 32'h1);
        check("wr_setup_data", 32'(bus.Data_write), 32'h5A5A);
        check("wr_addr", 32'(bus.ADDR), 32'h00012);
        step(1);
        check("wr_pulse1", 32'(strobes()), 32'h02);
        step(1);
        check("wr_pulse2", 32'(strobes()), 32'h02);
        step(1);
        check("wr_hold_strobes", 32'(strobes()), 32'h03);
        check("wr_hold_data", 32'(bus.Data_write), 32'h5A5A);
        step(1);
        check("wr_ready", 32'(bus.ready), 32'h1);
        check("wr_done_strobes", 32'(strobes()), 32'h1F);
        check("wr_done_doe", 32'(bus.Data_oe), 32'h0);
        step(1);
        check("wr_busy_end", 32'(bus.busy), 32'h0);
        check("wr_doe_count", doe_cyc - s_doe, 32'd4);
        check("wr_we_count", we_low_cyc - s_we, 32'd2);
        check("wr_ready_count", ready_cyc - s_rdy, 32'd1);
        check("wr_mem_addr", 32'(last_wr_addr), 32'h00012);
        check("wr_mem_data", 32'(last_wr_data), 32'h5A5A);
        check("wr_rdata_kept", 32'(bus.rdata), 32'hBEEF);

        // Read and write together: read wins
        s_we = we_low_cyc; s_rdy = ready_cyc;
        bus.addr = 16'h0001; bus.wdata = 16'hFFFF;
        bus.req_rd = 1'b1; bus.req_wr = 1'b1;
        step(1);
        bus.req_rd = 1'b0; bus.req_wr = 1'b0;
        check("both_strobes", 32'(strobes()), 32'h01);
        step(3);
        check("both_busy_end", 32'(bus.busy), 32'h0);
        check("both_rdata", 32'(bus.rdata), 32'h1234);
        check("both_we_count", we_low_cyc - s_we, 32'd0);
        check("both_ready_count", ready_cyc - s_rdy, 32'd1);

        // Request held for 12 edges: accepts at E0, E0+4, E0+8
        s_rdy = ready_cyc;
        bus.addr = 16'h3000; bus.req_rd = 1'b1;
        step(12);
        bus.req_rd = 1'b0;
        step(4);
        check("b2b_ready_count", ready_cyc - s_rdy, 32'd3);
        check("b2b_busy_end", 32'(bus.busy), 32'h0);
        check("b2b_rdata", 32'(bus.rdata), 32'hBEEF);

        // Reset during second WR_PULSE cycle
        s_rdy = ready_cyc;
        bus.addr = 16'h0012; bus.wdata = 16'h0F0F; bus.req_wr = 1'b1;
        step(1);
        bus.req_wr = 1'b0;
        step(2);
        check("abort_we_before", 32'(bus.WE), 32'h0);
        Reset = 1'b1;
        #1;
        check("abort_ce_we", 32'({bus.CE, bus.WE}), 32'h3);
        check("abort_doe", 32'(bus.Data_oe), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        step(2);
        Reset = 1'b0;
        step(3);
        check("abort_no_ready", ready_cyc - s_rdy, 32'd0);
        check("abort_rdata_rst", 32'(bus.rdata), 32'h0);
        s_rdy = ready_cyc;
        bus.addr = 16'h3000; bus.req_rd = 1'b1;
        step(1);
        bus.req_rd = 1'b0;
        step(3);
        check("post_rst_rdata", 32'(bus.rdata), 32'hBEEF);
        check("post_rst_ready", ready_cyc - s_rdy, 32'd1);
        check("post_rst_busy", 32'(bus.busy), 32'h0);

        check("invariants", viol, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
